// File: rtl/sel_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sel_arbiter_pkg
//  Purpose  : Shared types and constants for the sel_arbiter block: FSM state
//             encoding, mux-select encodings and the hold-counter width.
//  Revision : 1.0  initial release
// ============================================================================
package sel_arbiter_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2
    } state_t;

    // Downstream 2:1 mux select encodings
    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    // Hold counter width and its saturation value
    localparam int              CNT_W   = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

endpackage : sel_arbiter_pkg
`default_nettype wire

// File: rtl/sel_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : sel_arbiter
//  Purpose  : Two-source ownership arbiter driving the select of an existing
//             2:1 mux. Moore FSM (IDLE / GNT_A / GNT_B) with registered
//             outputs, round-robin tie break and zero-cycle handoff when the
//             owner releases while the other source is waiting.
//  Config   : SEL_ARBITER_TIMEOUT_EN - when defined, an owner that has held the
//             path for MAX_HOLD cycles is forced out if the other source is
//             requesting. When undefined, the hold counter is not built.
//  Ports    : clk      - clock, rising edge
//             rst_n    - asynchronous active-low reset
//             req_a    - source A request (level, held while ownership wanted)
//             req_b    - source B request
//             sel      - mux select, 0 = A, 1 = B; holds last value in IDLE
//             grant_a  - A owns the mux path
//             grant_b  - B owns the mux path
//             busy     - grant_a | grant_b
//  Revision : 1.0  initial release
// ============================================================================
module sel_arbiter
    import sel_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_a,
    input  logic req_b,
    output logic sel,
    output logic grant_a,
    output logic grant_b,
    output logic busy
);

    // Reject out-of-range hold limits at elaboration time
    if ((MAX_HOLD < 1) || (MAX_HOLD > 255)) begin : g_max_hold_check
        $error("sel_arbiter: MAX_HOLD must be in 1..255");
    end

    state_t r_state;
    state_t w_next_state;
    logic   r_last_served;   // SEL_A / SEL_B encoding of the last owner
    logic   w_enter_grant;
    logic   w_hold_expired;

`ifdef SEL_ARBITER_TIMEOUT_EN
    localparam logic [CNT_W-1:0] C_HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    logic [CNT_W-1:0] r_hold_cnt;

    // Counter reads 0 in the first grant cycle, so reaching MAX_HOLD-1 means
    // the owner has had MAX_HOLD cycles.
    assign w_hold_expired = (r_hold_cnt == C_HOLD_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_cnt <= '0;
        end else if (w_enter_grant) begin
            r_hold_cnt <= '0;
        end else if ((r_state != IDLE) && (r_hold_cnt != CNT_MAX)) begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
        end
    end
`else
    assign w_hold_expired = 1'b0;
`endif

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (req_a && req_b) begin
                    w_next_state = (r_last_served == SEL_B) ? GNT_A : GNT_B;
                end else if (req_a) begin
                    w_next_state = GNT_A;
                end else if (req_b) begin
                    w_next_state = GNT_B;
                end else begin
                    w_next_state = IDLE;
                end
            end
            GNT_A: begin
                if (!req_a) begin
                    w_next_state = req_b ? GNT_B : IDLE;
                end else if (req_b && w_hold_expired) begin
                    w_next_state = GNT_B;
                end else begin
                    w_next_state = GNT_A;
                end
            end
            GNT_B: begin
                if (!req_b) begin
                    w_next_state = req_a ? GNT_A : IDLE;
                end else if (req_a && w_hold_expired) begin
                    w_next_state = GNT_A;
                end else begin
                    w_next_state = GNT_B;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Entry into a grant state, including a direct A<->B handoff
    assign w_enter_grant = (w_next_state != r_state) && (w_next_state != IDLE);

    // State and outputs registered together; outputs are decoded from the
    // next state so they line up with the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_last_served <= SEL_B;
            sel           <= SEL_A;
            grant_a       <= 1'b0;
            grant_b       <= 1'b0;
            busy          <= 1'b0;
        end else begin
            r_state <= w_next_state;
            grant_a <= (w_next_state == GNT_A);
            grant_b <= (w_next_state == GNT_B);
            busy    <= (w_next_state != IDLE);
            // sel is left alone in IDLE so the mux output stays stable
            if (w_next_state == GNT_A) begin
                sel <= SEL_A;
            end else if (w_next_state == GNT_B) begin
                sel <= SEL_B;
            end
            if (w_enter_grant) begin
                r_last_served <= (w_next_state == GNT_B) ? SEL_B : SEL_A;
            end
        end
    end

endmodule : sel_arbiter
`default_nettype wire
